// File: rtl/store_buffer.sv
// =============================================================================
// Module      : store_buffer
// Description : FIFO store buffer sharing one data-memory port with loads;
//               optional store-to-load forwarding under macro STORE_FWD_EN.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module store_buffer #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            st_valid,
   input  logic [XLEN-1:0] st_addr,
   input  logic [XLEN-1:0] st_data,
   input  logic [2:0]      st_ctrl,
   output logic            st_ready,
   input  logic            ld_valid,
   input  logic [XLEN-1:0] ld_addr,
   input  logic [2:0]      ld_ctrl,
   output logic            ld_stall,
   output logic [XLEN-1:0] ld_data,
   input  logic [XLEN-1:0] mem_RD,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_A,
   output logic [XLEN-1:0] mem_WD,
   output logic [2:0]      mem_ctrl,
   output logic            empty
);

   localparam int AW = $clog2(DEPTH);

`ifdef STORE_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [AW:0]     count_q, count_d;
   logic [XLEN-1:0] ent_addr_q [DEPTH];
   logic [XLEN-1:0] ent_data_q [DEPTH];
   logic [2:0]      ent_ctrl_q [DEPTH];

   logic            full, push, pop, hazard, fwd_ok;
   logic [AW-1:0]   idx, yng_idx;
   logic [XLEN:0]   ld_end;
   logic [XLEN-1:0] fwd_data;

   function automatic logic [2:0] span_size(input logic [1:0] sz);
      case (sz)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Spans are compared in XLEN+1 bits so an access at the top of memory never wraps.
   function automatic logic [XLEN:0] span_end(input logic [XLEN-1:0] a, input logic [1:0] sz);
      return {1'b0, a} + (XLEN+1)'(span_size(sz));
   endfunction

   function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d, input logic [2:0] c);
      case (c)
         3'b000:  return {{(XLEN-8){d[7]}}, d[7:0]};
         3'b001:  return {{(XLEN-16){d[15]}}, d[15:0]};
         3'b100:  return {{(XLEN-8){1'b0}}, d[7:0]};
         3'b101:  return {{(XLEN-16){1'b0}}, d[15:0]};
         default: return d;
      endcase
   endfunction

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign st_ready = !full;
   assign push     = st_valid && !full;

   // Walk oldest to youngest so the last hit is the youngest overlapping entry.
   always_comb begin
      ld_end  = span_end(ld_addr, ld_ctrl[1:0]);
      hazard  = 1'b0;
      idx     = '0;
      yng_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + AW'(k);
         if (((AW+1)'(k) < count_q) &&
             ({1'b0, ent_addr_q[idx]} < ld_end) &&
             ({1'b0, ld_addr} < span_end(ent_addr_q[idx], ent_ctrl_q[idx][1:0]))) begin
            hazard  = ld_valid;
            yng_idx = idx;
         end
      end
      fwd_ok   = FWD_EN && hazard && (ent_addr_q[yng_idx] == ld_addr) &&
                 (span_size(ent_ctrl_q[yng_idx][1:0]) >= span_size(ld_ctrl[1:0]));
      fwd_data = load_ext(ent_data_q[yng_idx], ld_ctrl);
   end

   always_comb begin
      mem_we   = 1'b0;
      mem_A    = '0;
      mem_WD   = '0;
      mem_ctrl = 3'b000;
      ld_stall = 1'b0;
      ld_data  = '0;
      pop      = 1'b0;
      if (fwd_ok) begin
         ld_data = fwd_data;
         if (!empty) begin
            pop      = 1'b1;
            mem_we   = 1'b1;
            mem_A    = ent_addr_q[head_q];
            mem_WD   = ent_data_q[head_q];
            mem_ctrl = ent_ctrl_q[head_q];
         end
      end else if (ld_valid && !hazard && !full) begin
         mem_A    = ld_addr;
         mem_ctrl = ld_ctrl;
         ld_data  = mem_RD;
      end else if (!empty) begin
         pop      = 1'b1;
         mem_we   = 1'b1;
         mem_A    = ent_addr_q[head_q];
         mem_WD   = ent_data_q[head_q];
         mem_ctrl = ent_ctrl_q[head_q];
         ld_stall = ld_valid;
      end
   end

   always_comb begin
      head_d  = head_q + AW'(pop);
      tail_d  = tail_q + AW'(push);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr_q[tail_q] <= st_addr;
         ent_data_q[tail_q] <= st_data;
         ent_ctrl_q[tail_q] <= st_ctrl;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// =============================================================================
// Module      : tb_store_buffer
// Description : Directed bench for store_buffer with a byte-array memory model.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module tb_store_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_valid, ld_valid;
   logic [31:0] st_addr, st_data, ld_addr;
   logic [2:0]  st_ctrl, ld_ctrl;
   logic        st_ready, ld_stall, mem_we, empty;
   logic [31:0] ld_data, mem_RD, mem_A, mem_WD;
   logic [2:0]  mem_ctrl;

   int errors = 0;
   int checks = 0;
   int writes = 0;
   int w0;

   logic [7:0] mem [4096];

   always #5 clk = ~clk;

   store_buffer #(.XLEN(32), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ctrl(st_ctrl),
      .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ctrl(ld_ctrl),
      .ld_stall(ld_stall), .ld_data(ld_data),
      .mem_RD(mem_RD), .mem_we(mem_we), .mem_A(mem_A), .mem_WD(mem_WD),
      .mem_ctrl(mem_ctrl), .empty(empty)
   );

   assign mem_RD = {mem[mem_A[11:0] + 12'd3], mem[mem_A[11:0] + 12'd2],
                    mem[mem_A[11:0] + 12'd1], mem[mem_A[11:0]]};

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      forever begin
         @(posedge clk);
         if (mem_we) begin
            writes++;
            for (int b = 0; b < 4; b++)
               if (b < (mem_ctrl[1:0] == 2'b00 ? 1 : mem_ctrl[1:0] == 2'b01 ? 2 : 4))
                  mem[mem_A[11:0] + 12'(b)] <= mem_WD[8*b +: 8];
         end
      end
   end

   function automatic logic [31:0] rd32(input logic [11:0] a);
      return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 10 && !empty; i++) tick();
      chk(tag, 32'(empty), 32'd1);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
      st_valid = 1'b1; st_addr = a; st_data = d; st_ctrl = c;
   endtask

   task automatic load(input logic [31:0] a, input logic [2:0] c);
      ld_valid = 1'b1; ld_addr = a; ld_ctrl = c;
   endtask

   initial begin
      rst_n = 1'b0; st_valid = 1'b0; ld_valid = 1'b0;
      st_addr = '0; st_data = '0; st_ctrl = '0; ld_addr = '0; ld_ctrl = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_st_ready", 32'(st_ready), 32'd1);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_ld_stall", 32'(ld_stall), 32'd0);
      tick();

      // Single SW drains the cycle after it is pushed.
      store(32'h100, 32'hDEADBEEF, 3'b010);
      @(negedge clk);
      chk("sw_push_ready", 32'(st_ready), 32'd1);
      chk("sw_push_we", 32'(mem_we), 32'd0);
      tick();
      st_valid = 1'b0;
      @(negedge clk);
      chk("sw_drain_we", 32'(mem_we), 32'd1);
      chk("sw_drain_A", mem_A, 32'h100);
      chk("sw_drain_WD", mem_WD, 32'hDEADBEEF);
      chk("sw_drain_ctrl", 32'(mem_ctrl), 32'd2);
      chk("sw_drain_nempty", 32'(empty), 32'd0);
      tick();
      @(negedge clk);
      chk("sw_after_empty", 32'(empty), 32'd1);
      chk("sw_after_we", 32'(mem_we), 32'd0);
      chk("sw_mem", rd32(12'h100), 32'hDEADBEEF);
      tick();

      // Fill the buffer while non-overlapping loads hold the port.
      for (int k = 0; k < 4; k++) begin
         store(32'h500 + 32'(4 * k), 32'h11110000 + 32'(k), 3'b010);
         load(32'h800, 3'b010);
         @(negedge clk);
         chk("fill_ready", 32'(st_ready), 32'd1);
         chk("fill_we", 32'(mem_we), 32'd0);
         chk("fill_stall", 32'(ld_stall), 32'd0);
         tick();
      end
      st_valid = 1'b0;
      @(negedge clk);
      chk("full_ready", 32'(st_ready), 32'd0);
      chk("full_we", 32'(mem_we), 32'd1);
      chk("full_A", mem_A, 32'h500);
      chk("full_stall", 32'(ld_stall), 32'd1);
      tick();
      @(negedge clk);
      chk("unfull_ready", 32'(st_ready), 32'd1);
      chk("unfull_stall", 32'(ld_stall), 32'd0);
      chk("unfull_we", 32'(mem_we), 32'd0);
      chk("unfull_A", mem_A, 32'h800);
      tick();
      ld_valid = 1'b0;
      drain("fill_drain");
      chk("fill_mem_last", rd32(12'h50C), 32'h11110003);

      // SB overlapping an LW stalls the load until it drains.
      store(32'h203, 32'h00000080, 3'b000);
      tick();
      st_valid = 1'b0;
      load(32'h200, 3'b010);
      @(negedge clk);
      chk("sb_hz_stall", 32'(ld_stall), 32'd1);
      chk("sb_hz_we", 32'(mem_we), 32'd1);
      chk("sb_hz_A", mem_A, 32'h203);
      tick();
      @(negedge clk);
      chk("sb_ld_stall", 32'(ld_stall), 32'd0);
      chk("sb_ld_we", 32'(mem_we), 32'd0);
      chk("sb_ld_data", ld_data, 32'h80000000);
      tick();
      ld_valid = 1'b0;

      // Adjacent but non-overlapping spans do not stall.
      store(32'h300, 32'h00001234, 3'b001);
      tick();
      st_valid = 1'b0;
      load(32'h302, 3'b100);
      @(negedge clk);
      chk("sh_lbu_stall", 32'(ld_stall), 32'd0);
      chk("sh_lbu_we", 32'(mem_we), 32'd0);
      chk("sh_lbu_A", mem_A, 32'h302);
      chk("sh_lbu_ctrl", 32'(mem_ctrl), 32'd4);
      chk("sh_lbu_data", ld_data, 32'h00000000);
      chk("sh_lbu_nempty", 32'(empty), 32'd0);
      tick();
      ld_valid = 1'b0;
      drain("sh_drain");
      chk("sh_mem", rd32(12'h300), 32'h00001234);

`ifdef STORE_FWD_EN
      store(32'h600, 32'hCAFE0001, 3'b010);
      load(32'h800, 3'b010);
      tick();
      store(32'h400, 32'h000080FF, 3'b010);
      tick();
      st_valid = 1'b0;
      load(32'h400, 3'b000);
      @(negedge clk);
      chk("fwd_lb_stall", 32'(ld_stall), 32'd0);
      chk("fwd_lb_data", ld_data, 32'hFFFFFFFF);
      chk("fwd_lb_we", 32'(mem_we), 32'd1);
      chk("fwd_lb_A", mem_A, 32'h600);
      tick();
      load(32'h402, 3'b001);
      @(negedge clk);
      chk("fwd_lh_stall", 32'(ld_stall), 32'd1);
      chk("fwd_lh_A", mem_A, 32'h400);
      tick();
      @(negedge clk);
      chk("fwd_lh_done", 32'(ld_stall), 32'd0);
      chk("fwd_lh_we", 32'(mem_we), 32'd0);
      tick();
      ld_valid = 1'b0;
`else
      store(32'h400, 32'h000080FF, 3'b010);
      tick();
      st_valid = 1'b0;
      load(32'h400, 3'b000);
      @(negedge clk);
      chk("nofwd_lb_stall", 32'(ld_stall), 32'd1);
      chk("nofwd_lb_we", 32'(mem_we), 32'd1);
      chk("nofwd_lb_A", mem_A, 32'h400);
      tick();
      @(negedge clk);
      chk("nofwd_lb_done", 32'(ld_stall), 32'd0);
      chk("nofwd_lb_data", ld_data, 32'h000080FF);
      tick();
      ld_valid = 1'b0;
`endif

      // Reset with three pending stores discards them.
      for (int k = 0; k < 3; k++) begin
         store(32'h700 + 32'(4 * k), 32'(k + 1), 3'b010);
         load(32'h800, 3'b010);
         tick();
      end
      st_valid = 1'b0;
      rst_n = 1'b0;
      w0 = writes;
      @(negedge clk);
      chk("rst3_pre_we", 32'(mem_we), 32'd0);
      tick();
      rst_n = 1'b1;
      ld_valid = 1'b0;
      @(negedge clk);
      chk("rst3_empty", 32'(empty), 32'd1);
      chk("rst3_we", 32'(mem_we), 32'd0);
      repeat (5) tick();
      chk("rst3_no_writes", 32'(writes), 32'(w0));
      chk("rst3_mem", rd32(12'h700), 32'h00000000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
